// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and constants for the compare/sort controller
// Purpose: FSM state encoding and default geometry for compare_sort_ctrl.
// Ports: none (package).
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Index into the word array, and a counter that can hold DEPTH itself.
    localparam int IDX_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/sort_greater.sv
// rtl/sort_greater.sv - combinational unsigned a > b comparator
// Purpose: the single shared greater-than used by every compare/swap step.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   gt   : 1 when a > b (unsigned); equal operands give 0
module sort_greater #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/compare_sort_ctrl.sv
// rtl/compare_sort_ctrl.sv - frame bubble-sort controller with one shared comparator
// Purpose: load 1..DEPTH words, bubble-sort them one compare/swap per cycle,
//          then stream them out in ascending unsigned order.
// Build option: SORT_EARLY_EXIT_EN - leave SORT after any pass with no swaps.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last      : input word stream
//   out_valid/out_ready/out_data/out_last  : sorted output stream
//   busy                           : high while in SORT or DRAIN
module compare_sort_ctrl
    import sort_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   n;
    logic [IW-1:0]   pass;
    logic [IW-1:0]   i;
    logic [IW-1:0]   rd;
    logic            out_valid_r;

    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic             gt;
    logic             load_we;
    logic             frame_end;
    logic             swap_en;
    logic             pass_end;
    logic             last_pass;
    logic             exit_sort;
    logic             rd_last;

    assign a_w = mem[i];
    assign b_w = mem[i + IW'(1)];

    sort_greater #(.WIDTH(WIDTH)) u_gt (
        .a  (a_w),
        .b  (b_w),
        .gt (gt)
    );

    assign load_we   = (state == LOAD) && in_valid;
    assign frame_end = load_we && (in_last || (count == CW'(DEPTH - 1)));
    assign swap_en   = (state == SORT) && gt;

    // Pass limit is N-1-pass, so the pass ends when i == N-2-pass.
    assign pass_end  = (CW'(i) + CW'(pass) + CW'(2)) == n;
    assign last_pass = (CW'(pass) + CW'(2)) == n;
    assign rd_last   = (CW'(rd) + CW'(1)) == n;

`ifdef SORT_EARLY_EXIT_EN
    logic swapped;
    // The current compare counts toward this pass's swap record.
    assign exit_sort = pass_end && (last_pass || !(swapped || gt));
`else
    assign exit_sort = pass_end && last_pass;
`endif

    // Word array has no reset; only loaded entries are ever read.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[count[IW-1:0]] <= in_data;
        end else if (swap_en) begin
            mem[i]          <= b_w;
            mem[i + IW'(1)] <= a_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            count       <= '0;
            n           <= '0;
            pass        <= '0;
            i           <= '0;
            rd          <= '0;
            out_valid_r <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            swapped     <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (load_we) begin
                        count <= count + CW'(1);
                        if (frame_end) begin
                            n    <= count + CW'(1);
                            pass <= '0;
                            i    <= '0;
                            rd   <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swapped <= 1'b0;
`endif
                            if (count == '0) begin
                                state       <= DRAIN;
                                out_valid_r <= 1'b1;
                            end else begin
                                state <= SORT;
                            end
                        end
                    end
                end
                SORT: begin
                    if (exit_sort) begin
                        state       <= DRAIN;
                        out_valid_r <= 1'b1;
                        rd          <= '0;
                    end else if (pass_end) begin
                        pass <= pass + IW'(1);
                        i    <= '0;
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                    end else begin
                        i <= i + IW'(1);
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= swapped || gt;
`endif
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (rd_last) begin
                            state       <= LOAD;
                            count       <= '0;
                            out_valid_r <= 1'b0;
                        end else begin
                            rd <= rd + IW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Outputs come straight from registers; data/last stay fixed while stalled
    // because neither rd nor the array changes in DRAIN without a handshake.
    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = out_valid_r;
    assign out_data  = out_valid_r ? mem[rd] : '0;
    assign out_last  = out_valid_r && rd_last;

endmodule

// File: tb/tb_compare_sort_ctrl.sv
// tb/tb_compare_sort_ctrl.sv - self-checking bench for compare_sort_ctrl
module tb_compare_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    compare_sort_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int unsigned exp_q[$];
    int          got = 0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Ascending order, equal values kept in arrival order.
    task automatic build_expected(input int unsigned w[8], input int n);
        int pos;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            pos = 0;
            while (pos < exp_q.size() && exp_q[pos] <= w[k]) pos++;
            exp_q.insert(pos, w[k]);
        end
    endtask

    function automatic int model_sort_cycles(input int unsigned w[8], input int n);
`ifdef SORT_EARLY_EXIT_EN
        int unsigned a[8];
        int          cyc;
        int unsigned t;
        bit          sw;
        a   = w;
        cyc = 0;
        for (int p = 0; p < n - 1; p++) begin
            sw = 1'b0;
            for (int j = 0; j < n - 1 - p; j++) begin
                cyc++;
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t; sw = 1'b1;
                end
            end
            if (!sw) break;
        end
        return cyc;
`else
        return (n * (n - 1)) / 2;
`endif
    endfunction

    // Output monitor: every valid cycle is checked against the model queue.
    logic [7:0] prev_data;
    logic       prev_last;
    bit         prev_stall = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid && mon_en) begin
            if (prev_stall) begin
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (got < exp_q.size()) begin
                check("out_data", out_data, exp_q[got]);
                check("out_last", out_last, got == exp_q.size() - 1);
            end else begin
                tests++;
                fails++;
                $display("FAIL extra_word: got word %0h after %0d expected words", out_data, exp_q.size());
            end
            prev_data  = out_data;
            prev_last  = out_last;
            prev_stall = !out_ready;
            if (out_ready) got++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_words(input int unsigned w[8], input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = w[k][7:0];
            in_last  = use_last && (k == n - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int unsigned w[8], input int n,
                             input bit use_last, input bit toggle);
        int sort_cnt;
        int drain_cnt;
        build_expected(w, n);
        got       = 0;
        mon_en    = 1'b1;
        out_ready = toggle ? 1'b0 : 1'b1;
        send_words(w, n, use_last);
        sort_cnt  = 0;
        drain_cnt = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (out_valid) break;
            if (busy) sort_cnt++;
            check({tag, "_in_ready_busy"}, in_ready, 1'b0);
        end
        check({tag, "_sort_cycles"}, sort_cnt, model_sort_cycles(w, n));
        for (int c = 0; c < 200; c++) begin
            if (!busy) break;
            if (out_valid) drain_cnt++;
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            @(negedge clk);
        end
        check({tag, "_words_out"}, got, n);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_in_ready_after"}, in_ready, 1'b1);
        if (!toggle) check({tag, "_drain_cycles"}, drain_cnt, n);
    endtask

    int unsigned fa[8] = '{5, 3, 8, 1, 9, 2, 7, 4};
    int unsigned fb[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int unsigned fc[8] = '{8'h2F, 8'h81, 8'h80, 8'h00, 0, 0, 0, 0};
    int unsigned fd[8] = '{8'hAA, 0, 0, 0, 0, 0, 0, 0};
    int unsigned fe[8] = '{7, 7, 3, 0, 0, 0, 0, 0};
    int unsigned fg[8] = '{2, 1, 0, 0, 0, 0, 0, 0};
    int unsigned lit_a[8] = '{1, 2, 3, 4, 5, 7, 8, 9};

    initial begin
        int sc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("A", fa, 8, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) check("A_model_order", exp_q[k], lit_a[k]);
`ifndef SORT_EARLY_EXIT_EN
        check("A_model_cycles", model_sort_cycles(fa, 8), 28);
        check("C_model_cycles", model_sort_cycles(fc, 4), 6);
`else
        check("B_model_cycles", model_sort_cycles(fb, 8), 7);
`endif

        run_frame("B", fb, 8, 1'b0, 1'b0);
        run_frame("C", fc, 4, 1'b1, 1'b0);
        check("C_model_max", exp_q[3], 8'h81);
        run_frame("D", fd, 1, 1'b1, 1'b0);
        run_frame("E", fe, 3, 1'b1, 1'b1);

        mon_en = 1'b0;
        out_ready = 1'b1;
        send_words(fa, 8, 1'b1);
        sc = 0;
        for (int c = 0; c < 50 && sc < 4; c++) begin
            @(negedge clk);
            if (busy && !out_valid) sc++;
        end
        check("F_sort_seen", sc, 4);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("F_async_out_valid", out_valid, 1'b0);
        check("F_async_busy", busy, 1'b0);
        check("F_async_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("F_no_output", out_valid, 1'b0);
        end

        run_frame("G", fg, 2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
